// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one pipelined unsigned multiplier among NREQ requesters.
// Optional stall statistic is compiled in when MUL_SHARE_ARBITER_STATS_EN is defined.
module mul_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned B_WIDTH = 8,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_x,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*A_WIDTH-1:0]    req_a,
    input  logic [NREQ*B_WIDTH-1:0]    req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [A_WIDTH+B_WIDTH-1:0] rsp_product,
    output logic [15:0]                stat_stall_cnt
);

    localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

    logic [A_WIDTH-1:0] w_a [NREQ];
    logic [B_WIDTH-1:0] w_b [NREQ];

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
        assign w_a[gi] = req_a[gi*A_WIDTH +: A_WIDTH];
        assign w_b[gi] = req_b[gi*B_WIDTH +: B_WIDTH];
    end

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_vld  [LATENCY];
    logic [ID_W-1:0]    r_id   [LATENCY];
    logic [P_WIDTH-1:0] r_prod [LATENCY];

    logic               w_advance;
    logic [NREQ-1:0]    w_rot;
    logic               w_found;
    int unsigned        w_scan_idx;
    int unsigned        w_next_idx;
    logic [NREQ-1:0]    w_grant_oh;
    logic [ID_W-1:0]    w_grant_id;
    logic [ID_W-1:0]    w_next_ptr;
    logic [A_WIDTH-1:0] w_sel_a;
    logic [B_WIDTH-1:0] w_sel_b;
    logic [P_WIDTH-1:0] w_product;

    // The whole pipeline freezes only while a response is presented and not taken.
    assign w_advance = !(r_vld[LATENCY-1] && !rsp_ready);

    // Rotate the request vector so bit 0 is the requester at r_rr_ptr.
    assign w_rot = NREQ'({req_valid, req_valid} >> r_rr_ptr);

    always_comb begin
        w_found    = 1'b0;
        w_scan_idx = 0;
        w_next_idx = 0;
        w_grant_oh = '0;
        w_grant_id = '0;
        w_next_ptr = r_rr_ptr;
        if (rst_x && w_advance) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!w_found && w_rot[k]) begin
                    w_found    = 1'b1;
                    w_scan_idx = 32'(r_rr_ptr) + k;
                    if (w_scan_idx >= NREQ) begin
                        w_scan_idx = w_scan_idx - NREQ;
                    end
                end
            end
        end
        if (w_found) begin
            w_next_idx = w_scan_idx + 1;
            if (w_next_idx >= NREQ) begin
                w_next_idx = 0;
            end
            w_grant_id = ID_W'(w_scan_idx);
            w_next_ptr = ID_W'(w_next_idx);
            for (int unsigned i = 0; i < NREQ; i++) begin
                w_grant_oh[i] = (w_scan_idx == i);
            end
        end
    end

    assign req_ready = w_grant_oh;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_a = w_a[i];
                w_sel_b = w_b[i];
            end
        end
    end

    assign w_product = P_WIDTH'(w_sel_a) * P_WIDTH'(w_sel_b);

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            r_rr_ptr <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_vld[s]  <= 1'b0;
                r_id[s]   <= '0;
                r_prod[s] <= '0;
            end
        end else if (w_advance) begin
            if (w_found) begin
                r_rr_ptr <= w_next_ptr;
            end
            r_vld[0]  <= w_found;
            r_id[0]   <= w_grant_id;
            r_prod[0] <= w_product;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_id[s]   <= r_id[s-1];
                r_prod[s] <= r_prod[s-1];
            end
        end
    end

    assign rsp_valid   = r_vld[LATENCY-1];
    assign rsp_id      = r_id[LATENCY-1];
    assign rsp_product = r_prod[LATENCY-1];

`ifdef MUL_SHARE_ARBITER_STATS_EN
    logic [15:0] r_stall_cnt;

    // Counts cycles in which a requester waits behind a blocked response; saturating.
    always_ff @(posedge clk) begin
        if (!rst_x) begin
            r_stall_cnt <= '0;
        end else if (!w_advance && (|req_valid) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stat_stall_cnt = r_stall_cnt;
`else
    assign stat_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (NREQ=4, 8x8, LATENCY=2).
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_x;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_product;
    logic [15:0] stat_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] prod_tab [4];

`ifdef MUL_SHARE_ARBITER_STATS_EN
    localparam logic [15:0] StatBp  = 16'd5;
    localparam logic [15:0] StatSat = 16'hFFFF;
`else
    localparam logic [15:0] StatBp  = 16'd0;
    localparam logic [15:0] StatSat = 16'd0;
`endif

    mul_share_arbiter #(
        .NREQ    (4),
        .A_WIDTH (8),
        .B_WIDTH (8),
        .LATENCY (2),
        .ID_W    (2)
    ) dut (
        .clk            (clk),
        .rst_x          (rst_x),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_product    (rsp_product),
        .stat_stall_cnt (stat_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [15:0] prod);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_id"}, {30'd0, rsp_id}, {30'd0, id});
        chk({tag, "_prod"}, {16'd0, rsp_product}, {16'd0, prod});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        prod_tab[0] = 16'd15;  // 3*5
        prod_tab[1] = 16'd28;  // 4*7
        prod_tab[2] = 16'd45;  // 5*9
        prod_tab[3] = 16'd66;  // 6*11
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 3), 8'(2 * i + 5));

        // Reset state, with a request already asserted
        rst_x     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        set_ops(1, 8'd13, 8'd11);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_rsp_product", {16'd0, rsp_product}, 32'd0);
        chk("rst_stat", {16'd0, stat_stall_cnt}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);

        // Single request
        rst_x = 1'b1;
        #1;
        chk("single_ready", {28'd0, req_ready}, 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("single_early", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk_rsp("single", 2'd1, 16'd143);
        @(negedge clk);
        #1;
        chk("single_done", {31'd0, rsp_valid}, 32'd0);
        set_ops(1, 8'd4, 8'd7);

        // Pulse reset so the rotation starts at 0
        @(negedge clk);
        rst_x = 1'b0;
        @(negedge clk);
        rst_x = 1'b1;

        // Round-robin with all requesters valid for 8 cycles
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            req_valid = (j < 8) ? 4'hF : 4'h0;
            #1;
            chk("rr_ready", {28'd0, req_ready}, (j < 8) ? (32'h1 << (j % 4)) : 32'h0);
            if (j >= 2 && j < 10) chk_rsp("rr_rsp", 2'((j - 2) % 4), prod_tab[(j - 2) % 4]);
            else chk("rr_rsp_idle", {31'd0, rsp_valid}, 32'd0);
        end

        // Backpressure: three accepts, then 5 stalled cycles
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'hF;
            rsp_ready = 1'b1;
            #1;
            chk("bp_ready", {28'd0, req_ready}, 32'h1 << k);
            if (k == 2) chk_rsp("bp_first", 2'd0, 16'd15);
            else chk("bp_fill", {31'd0, rsp_valid}, 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            req_valid = 4'hF;
            #1;
            chk("bp_stall_ready", {28'd0, req_ready}, 32'd0);
            chk_rsp("bp_frozen", 2'd1, 16'd28);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 4'h0;
        #1;
        chk_rsp("bp_release", 2'd1, 16'd28);
        chk("bp_stat", {16'd0, stat_stall_cnt}, {16'd0, StatBp});
        @(negedge clk);
        #1;
        chk_rsp("bp_last", 2'd2, 16'd45);
        @(negedge clk);
        #1;
        chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

        // Wrap from requester 3 to 0 with all-ones operands
        @(negedge clk);
        set_ops(0, 8'hFF, 8'hFF);
        set_ops(3, 8'hFF, 8'hFF);
        req_valid = 4'b1001;
        #1;
        chk("wrap_ready3", {28'd0, req_ready}, 32'h8);
        @(negedge clk);
        #1;
        chk("wrap_ready0", {28'd0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk_rsp("wrap_rsp3", 2'd3, 16'hFE01);
        @(negedge clk);
        #1;
        chk_rsp("wrap_rsp0", 2'd0, 16'hFE01);
        @(negedge clk);
        #1;
        chk("wrap_done", {31'd0, rsp_valid}, 32'd0);

        // Reset with two products in flight; pointer left at 2 beforehand
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        chk("mid_ready0", {28'd0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        chk("mid_ready1", {28'd0, req_ready}, 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        rst_x     = 1'b0;
        #1;
        chk_rsp("mid_pre", 2'd0, 16'hFE01);
        chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_x     = 1'b1;
        req_valid = 4'b0110;
        #1;
        chk("mid_dropped0", {31'd0, rsp_valid}, 32'd0);
        chk("mid_grant", {28'd0, req_ready}, 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("mid_dropped1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk_rsp("mid_new", 2'd1, 16'd28);
        @(negedge clk);
        #1;
        chk("mid_done", {31'd0, rsp_valid}, 32'd0);

        // Long stall with a pending request to saturate the statistic
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        chk("sat_ready", {28'd0, req_ready}, 32'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk_rsp("sat_hold", 2'd2, 16'd45);
        chk("sat_ready_blocked", {28'd0, req_ready}, 32'd0);
        repeat (65540) @(negedge clk);
        #1;
        chk("sat_stat", {16'd0, stat_stall_cnt}, {16'd0, StatSat});
        chk_rsp("sat_frozen", 2'd2, 16'd45);
        chk("sat_ready_still", {28'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        chk("sat_drained", {31'd0, rsp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
